// File: rtl/multi_stop_tdc.sv
// Multi-channel start/stop TDC: counts cycles from a shared start edge to the first
// edge on each stop input and publishes all channels as one sequenced record.
module multi_stop_tdc #(
  parameter int unsigned NCHAN          = 4,
  parameter int unsigned INTERVAL_WIDTH = 12,
  parameter int unsigned SEQ_WIDTH      = 16,
  parameter int unsigned DEADTIME_TICKS = 2000000,
  parameter bit          ACTIVE_LOW     = 1'b1,
  parameter string       DEBUG          = "false"
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              start_in,
  input  logic [NCHAN-1:0]                  stop_in,
  output logic [NCHAN*INTERVAL_WIDTH-1:0]   dout,
  output logic [NCHAN-1:0]                  hit,
  output logic [SEQ_WIDTH-1:0]              seq,
  output logic                              valid,
  output logic                              busy
);

  localparam int unsigned DOUT_W = NCHAN * INTERVAL_WIDTH;
  localparam int unsigned DT_W   = $clog2(DEADTIME_TICKS + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  localparam logic [INTERVAL_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [DT_W-1:0]           DEAD_LOAD = DT_W'(DEADTIME_TICKS - 1);

  // Polarity is folded in ahead of the synchroniser so a reset value of 0 reads as inactive.
  logic             start_m, start_s, start_d;
  logic [NCHAN-1:0] stop_m, stop_s;
  logic             start_rise_c;

  (* mark_debug = DEBUG *) logic [1:0]                state;
  (* mark_debug = DEBUG *) logic [INTERVAL_WIDTH-1:0] cnt;
  logic [DT_W-1:0]           dcnt;
  logic [SEQ_WIDTH-1:0]      seq_int;
  logic [NCHAN-1:0]          flag;
  logic [INTERVAL_WIDTH-1:0] res [NCHAN];

  logic [1:0]                state_nxt;
  logic [INTERVAL_WIDTH-1:0] cnt_nxt;
  logic [DT_W-1:0]           dcnt_nxt;
  logic [SEQ_WIDTH-1:0]      seq_int_nxt;
  logic [NCHAN-1:0]          flag_nxt;
  logic [INTERVAL_WIDTH-1:0] res_nxt [NCHAN];
  logic [DOUT_W-1:0]         dout_nxt;
  logic [NCHAN-1:0]          hit_nxt;
  logic [SEQ_WIDTH-1:0]      seq_nxt;
  logic                      valid_nxt;
  logic                      busy_nxt;

  if (DEBUG == "true") begin : g_debug_on
  end

  // Two-flop synchronisers plus start edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_m <= 1'b0;
      start_s <= 1'b0;
      start_d <= 1'b0;
      stop_m  <= '0;
      stop_s  <= '0;
    end else begin
      start_m <= start_in ^ ACTIVE_LOW;
      start_s <= start_m;
      start_d <= start_s;
      stop_m  <= stop_in ^ {NCHAN{ACTIVE_LOW}};
      stop_s  <= stop_m;
    end
  end

  assign start_rise_c = start_s & ~start_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      dcnt    <= '0;
      seq_int <= '0;
      flag    <= '0;
      res     <= '{default: '0};
      dout    <= '0;
      hit     <= '0;
      seq     <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      dcnt    <= dcnt_nxt;
      seq_int <= seq_int_nxt;
      flag    <= flag_nxt;
      res     <= res_nxt;
      dout    <= dout_nxt;
      hit     <= hit_nxt;
      seq     <= seq_nxt;
      valid   <= valid_nxt;
      busy    <= busy_nxt;
    end
  end

  // Next-state and capture logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    dcnt_nxt    = dcnt;
    seq_int_nxt = seq_int;
    flag_nxt    = flag;
    res_nxt     = res;
    dout_nxt    = dout;
    hit_nxt     = hit;
    seq_nxt     = seq;
    valid_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        dcnt_nxt = DEAD_LOAD;
        // A start while any stop is already active would give a bogus zero interval
        if (enable && start_rise_c && (stop_s == '0)) begin
          state_nxt   = ST_RUN;
          cnt_nxt     = INTERVAL_WIDTH'(1);
          seq_int_nxt = seq_int + 1'b1;
          flag_nxt    = '0;
        end
      end
      ST_RUN: begin
        cnt_nxt = cnt + 1'b1;
        for (int unsigned i = 0; i < NCHAN; i++) begin
          if (!flag[i] && stop_s[i]) begin
            res_nxt[i]  = cnt;
            flag_nxt[i] = 1'b1;
          end
        end
        if ((&flag_nxt) || (cnt == CNT_MAX)) begin
          state_nxt = ST_DEAD;
          for (int unsigned i = 0; i < NCHAN; i++) begin
            dout_nxt[i*INTERVAL_WIDTH +: INTERVAL_WIDTH] = flag_nxt[i] ? res_nxt[i] : CNT_MAX;
          end
          hit_nxt   = flag_nxt;
          seq_nxt   = seq_int;
          valid_nxt = 1'b1;
        end
      end
      ST_DEAD: begin
        dcnt_nxt = dcnt - 1'b1;
        if (dcnt == '0) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_multi_stop_tdc.sv
// Directed bench for multi_stop_tdc: three instances cover basic/deadtime/seq-wrap/reset
// (active low), timeout with a 4-bit interval, and active-high inputs.
module tb_multi_stop_tdc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  int   cyc = 0;

  logic       st [3];
  logic [3:0] sp [3];
  logic       vld [3];

  logic [31:0] dout0;  logic [3:0] hit0;  logic [1:0]  seq0;  logic busy0;
  logic [15:0] dout1;  logic [3:0] hit1;  logic [15:0] seq1;  logic busy1;
  logic [31:0] dout2;  logic [3:0] hit2;  logic [15:0] seq2;  logic busy2;

  int n_run = 0;
  int n_fail = 0;
  int vcnt [3] = '{0, 0, 0};
  int vcyc [3] = '{0, 0, 0};
  int c0 [3]   = '{0, 0, 0};
  int vbase [3] = '{0, 0, 0};

  multi_stop_tdc #(.NCHAN(4), .INTERVAL_WIDTH(8), .SEQ_WIDTH(2), .DEADTIME_TICKS(10),
                   .ACTIVE_LOW(1'b1), .DEBUG("false")) u_lo (
    .clk(clk), .rst_n(rst_n), .enable(en), .start_in(st[0]), .stop_in(sp[0]),
    .dout(dout0), .hit(hit0), .seq(seq0), .valid(vld[0]), .busy(busy0));

  multi_stop_tdc #(.NCHAN(4), .INTERVAL_WIDTH(4), .SEQ_WIDTH(16), .DEADTIME_TICKS(2),
                   .ACTIVE_LOW(1'b1), .DEBUG("false")) u_to (
    .clk(clk), .rst_n(rst_n), .enable(en), .start_in(st[1]), .stop_in(sp[1]),
    .dout(dout1), .hit(hit1), .seq(seq1), .valid(vld[1]), .busy(busy1));

  multi_stop_tdc #(.NCHAN(4), .INTERVAL_WIDTH(8), .SEQ_WIDTH(16), .DEADTIME_TICKS(2),
                   .ACTIVE_LOW(1'b0), .DEBUG("true")) u_hi (
    .clk(clk), .rst_n(rst_n), .enable(en), .start_in(st[2]), .stop_in(sp[2]),
    .dout(dout2), .hit(hit2), .seq(seq2), .valid(vld[2]), .busy(busy2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Valid pulse monitor: count pulses and note the edge index they followed
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i]) begin
        vcnt[i] <= vcnt[i] + 1;
        vcyc[i] <= cyc;
      end
    end
  end

  function automatic logic act(input int inst);
    return (inst == 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_run++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic release_all(input int inst);
    st[inst] = ~act(inst);
    sp[inst] = {4{~act(inst)}};
  endtask

  // Start at the current edge; stop channel i d[i] edges later (0 = never); then await valid
  task automatic meas(input int inst, input int d0, input int d1, input int d2, input int d3,
                      input int tmax);
    int d [4];
    int n;
    d = '{d0, d1, d2, d3};
    vbase[inst] = vcnt[inst];
    c0[inst] = cyc;
    st[inst] = act(inst);
    for (int t = 1; t <= tmax; t++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (d[i] == t) sp[inst][i] = act(inst);
      end
    end
    release_all(inst);
    n = 0;
    while (vcnt[inst] == vbase[inst] && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) release_all(i);
    idle(3);
    chk("rst_dout", dout0, 0);
    chk("rst_hit", hit0, 0);
    chk("rst_seq", seq0, 0);
    chk("rst_valid", vld[0], 0);
    chk("rst_busy", busy0, 0);
    rst_n = 1'b1;
    idle(4);
    chk("idle_busy", busy0, 0);

    // Basic timing, active low
    meas(0, 5, 10, 15, 20, 25);
    chk("basic_dout", dout0, 32'h140F0A05);
    chk("basic_hit", hit0, 4'hF);
    chk("basic_seq", seq0, 1);
    chk("basic_vcnt", vcnt[0], 1);
    chk("basic_lat", vcyc[0] - c0[0], 23);
    chk("basic_dead_busy", busy0, 1);

    // Start rising 5 cycles after valid lands in DEAD and is dropped
    tick();
    st[0] = 1'b0;
    idle(20);
    chk("dead5_busy", busy0, 0);
    chk("dead5_vcnt", vcnt[0], 1);
    chk("dead5_seq", seq0, 1);
    release_all(0);
    idle(3);

    meas(0, 2, 2, 2, 2, 6);
    chk("m2_dout", dout0, 32'h02020202);
    chk("m2_seq", seq0, 2);
    chk("m2_lat", vcyc[0] - c0[0], 5);

    // Start rising on the last DEAD cycle is still dropped
    while (cyc < vcyc[0] + 7) tick();
    st[0] = 1'b0;
    idle(15);
    chk("dead9_vcnt", vcnt[0], 2);
    chk("dead9_busy", busy0, 0);
    release_all(0);
    idle(3);

    meas(0, 1, 7, 4, 9, 12);
    chk("m3_dout", dout0, 32'h09040701);
    chk("m3_hit", hit0, 4'hF);
    chk("m3_seq", seq0, 3);

    // Start rising on the first IDLE cycle is accepted; seq wraps to 0
    while (cyc < vcyc[0] + 8) tick();
    meas(0, 3, 3, 3, 3, 8);
    chk("dead10_vcnt", vcnt[0], 4);
    chk("dead10_seq", seq0, 0);
    chk("dead10_lat", vcyc[0] - c0[0], 6);
    idle(14);

    // Start while stop[1] is active is rejected
    sp[0][1] = 1'b0;
    idle(4);
    st[0] = 1'b0;
    idle(12);
    chk("rej_stop_busy", busy0, 0);
    chk("rej_stop_vcnt", vcnt[0], 4);
    chk("rej_stop_seq", seq0, 0);
    release_all(0);
    idle(4);

    // Start with enable low is ignored
    en = 1'b0;
    st[0] = 1'b0;
    idle(12);
    chk("rej_en_busy", busy0, 0);
    chk("rej_en_vcnt", vcnt[0], 4);
    release_all(0);
    idle(4);
    en = 1'b1;

    meas(0, 4, 4, 4, 4, 8);
    chk("m6_seq", seq0, 1);
    chk("m6_dout", dout0, 32'h04040404);
    idle(14);

    // Timeout on a 4-bit interval
    meas(1, 3, 3, 0, 3, 20);
    chk("to_dout", dout1, 16'h3F33);
    chk("to_hit", hit1, 4'b1011);
    chk("to_seq", seq1, 1);
    chk("to_lat", vcyc[1] - c0[1], 18);
    idle(4);

    // Stop seen on the all-ones cycle counts as a hit
    meas(1, 15, 0, 0, 0, 20);
    chk("to_max_dout", dout1, 16'hFFFF);
    chk("to_max_hit", hit1, 4'b0001);
    chk("to_max_seq", seq1, 2);
    chk("to_max_lat", vcyc[1] - c0[1], 18);
    idle(4);

    // Active-high inputs give the same intervals
    meas(2, 5, 10, 15, 20, 25);
    chk("hi_dout", dout2, 32'h140F0A05);
    chk("hi_hit", hit2, 4'hF);
    chk("hi_seq", seq2, 1);
    chk("hi_lat", vcyc[2] - c0[2], 23);
    idle(4);

    // Reset in the middle of a run
    st[0] = 1'b0;
    idle(6);
    chk("mid_busy", busy0, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", dout0, 0);
    chk("mid_rst_hit", hit0, 0);
    chk("mid_rst_seq", seq0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_valid", vld[0], 0);
    release_all(0);
    idle(2);
    rst_n = 1'b1;
    idle(15);
    chk("mid_rst_vcnt", vcnt[0], 5);
    meas(0, 5, 10, 15, 20, 25);
    chk("post_rst_seq", seq0, 1);
    chk("post_rst_dout", dout0, 32'h140F0A05);
    chk("post_rst_lat", vcyc[0] - c0[0], 23);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_stop_tdc.md
# multi_stop_tdc

Multi-channel time-to-digital converter. It measures the clock-cycle interval from one shared start edge to the first active edge on each of NCHAN independent stop inputs. All channels of a measurement are published together as one record, with a sequence number and a per-channel hit mask. It generalises the single-channel start/stop TDC in the timing-diagnostics path, and feeds the register/readout layer through a one-cycle valid strobe.

## Interface
- NCHAN, 4, number of stop channels (1..32)
- INTERVAL_WIDTH, 12, bits per channel interval; also sets the timeout
- SEQ_WIDTH, 16, measurement sequence counter width
- DEADTIME_TICKS, 2000000, cycles the block ignores inputs after each publish (>=1)
- ACTIVE_LOW, 1, 1: inputs are active low (falling edges); 0: active high
- DEBUG, "false", value of the mark_debug attribute on internal state
- clk  input  1  sole clock
- rst_n  input  1  reset; asynchronous assert, active low
- enable  input  1  allows a new measurement to arm; sampled only in IDLE
- start_in  input  1  asynchronous start input
- stop_in  input  NCHAN  asynchronous stop inputs
- dout  output  NCHAN*INTERVAL_WIDTH  channel i interval in bits [i*INTERVAL_WIDTH +: INTERVAL_WIDTH]
- hit  output  NCHAN  1 = channel stopped before timeout
- seq  output  SEQ_WIDTH  sequence number of the published record
- valid  output  1  one-cycle pulse when dout/hit/seq update
- busy  output  1  state != IDLE

## Operation
- Input conditioning:
  - Every input passes through a 2-flop synchroniser and is XORed with ACTIVE_LOW to give internal active-high start_s and stop_s[i].
  - start_d is start_s delayed one cycle.
  - start_rise = start_s & !start_d.
- State machine: IDLE, RUN, DEAD.
- IDLE:
  - Load deadtime counter with DEADTIME_TICKS-1.
  - If enable & start_rise & (stop_s == 0): go to RUN, counter <= 1, seq_int <= seq_int+1, clear per-channel captured flags.
  - A start while any stop_s is asserted is rejected and the block stays in IDLE.
- RUN, each cycle:
  - counter <= counter+1.
  - For each channel with its flag clear and stop_s[i]=1: capture the current counter into res[i] and set flag[i].
  - Exit condition: all flags set (including captures made this cycle), or counter == all-ones.
  - On exit:
    - dout[i] <= flag/capture ? res[i] : all-ones.
    - hit <= flags including this cycle's captures.
    - seq <= seq_int; valid <= 1; go to DEAD.
  - A stop seen on the same cycle counter == all-ones counts as a hit with value all-ones.
- DEAD:
  - Decrement the deadtime counter; go to IDLE on the cycle it reads 0.
  - Starts and stops are ignored.
- enable is not consulted in RUN or DEAD; deasserting it mid-measurement does not abort the measurement.
- Once a channel has captured, later stop activity on it is ignored for that measurement.
- Arithmetic:
  - counter is INTERVAL_WIDTH bits and never wraps: RUN always exits at all-ones.
  - seq_int wraps modulo 2^SEQ_WIDTH. The first record after reset has seq=1.
- Reset (rst_n low, asynchronous):
  - dout, hit, seq, valid, seq_int and all synchroniser flops go to 0; state goes to IDLE.
  - A measurement in progress is discarded with no valid pulse.
  - After release, the block needs a fresh start edge; the synchroniser reset value of 0 means no spurious edge.

## Timing
- Input to internal signal latency is 2 cycles, identical for start and stop, so intervals are unbiased.
- Start edge on cycle S (start_rise=1) puts the block in RUN at S+1 with counter=1.
- A stop first seen at S+k (k>=1) captures value k.
- Exit decided in cycle E gives dout/hit/seq updated and valid=1 at E+1, in state DEAD.
- The last channel's capture and the exit happen in the same cycle, so valid appears 1 cycle after the final stop is seen.
- Timeout: with no stops, E = S + 2^INTERVAL_WIDTH - 1.
- DEAD lasts exactly DEADTIME_TICKS cycles; the earliest accepted next start_rise is at E+1+DEADTIME_TICKS.
- dout, hit and seq hold their values until the next publish or reset.
- valid is never high on consecutive cycles.
- busy is registered from state: high from S+1 through the last DEAD cycle.

## Test plan
- Basic timing. Setup: NCHAN=4, ACTIVE_LOW=1. Stimulus: falling start, then stop falls 5/10/15/20 cycles later. Required response: dout = {20,15,10,5}, hit=4'b1111, seq=1, valid 1 cycle after the ch3 capture.
- Timeout. Setup: INTERVAL_WIDTH=4. Stimulus: ch2 never stops, others stop at 3. Required response: ch2=15, others=3, hit=4'b1011, valid at S+16.
- Rejections.
  - Stimulus: start edge while stop_in[1] is held active. Required response: no RUN, busy stays 0, seq unchanged.
  - Stimulus: start edge with enable=0. Required response: the start is ignored.
- Deadtime. Setup: DEADTIME_TICKS=10. Stimulus: start at valid+5. Required response: the start is ignored.
  - Stimulus: start at valid+10 or later. Required response: the start is accepted.
- Reset mid-operation. Stimulus: assert rst_n low mid-RUN. Required response: outputs 0 immediately, no valid. The next measurement returns seq=1.
- Edge cases.
  - Setup: SEQ_WIDTH=2. Stimulus: 5 measurements. Required response: seq = 1,2,3,0,1.
  - Setup: ACTIVE_LOW=0. Stimulus: rising edges. Required response: the same intervals as the basic timing case.
